ped_crossing_ctrl: RTL and testbench



---
 rtl/ped_crossing_pkg.sv | 42 ++++
 rtl/tick_prescaler.sv | 43 ++++
 rtl/ped_crossing_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ped_crossing_pkg.sv
// Shared types for the pedestrian crossing controller: FSM state encoding,
// lamp-vector field positions and the Moore lamp decode.
package ped_crossing_pkg;

    typedef enum logic [2:0] {
        ST_CAR_GREEN      = 3'd0,
        ST_CAR_YELLOW     = 3'd1,
        ST_ALL_RED_1      = 3'd2,
        ST_PED_GREEN      = 3'd3,
        ST_PED_FLASH      = 3'd4,
        ST_ALL_RED_2      = 3'd5,
        ST_CAR_RED_YELLOW = 3'd6,
        ST_NIGHT_FLASH    = 3'd7
    } state_t;

    localparam int LAMP_W           = 5;
    localparam int LAMP_ROAD_RED    = 4;
    localparam int LAMP_ROAD_YELLOW = 3;
    localparam int LAMP_ROAD_GREEN  = 2;
    localparam int LAMP_PED_RED     = 1;
    localparam int LAMP_PED_GREEN   = 0;

    function automatic logic [LAMP_W-1:0] lamp_decode(input state_t st, input logic blink);
        logic [LAMP_W-1:0] l;
        l = 5'b00000;
        case (st)
            ST_CAR_GREEN:      begin l[LAMP_ROAD_GREEN] = 1'b1; l[LAMP_PED_RED] = 1'b1; end
            ST_CAR_YELLOW:     begin l[LAMP_ROAD_YELLOW] = 1'b1; l[LAMP_PED_RED] = 1'b1; end
            ST_ALL_RED_1:      begin l[LAMP_ROAD_RED] = 1'b1; l[LAMP_PED_RED] = 1'b1; end
            ST_PED_GREEN:      begin l[LAMP_ROAD_RED] = 1'b1; l[LAMP_PED_GREEN] = 1'b1; end
            ST_PED_FLASH:      begin l[LAMP_ROAD_RED] = 1'b1; l[LAMP_PED_GREEN] = blink; end
            ST_ALL_RED_2:      begin l[LAMP_ROAD_RED] = 1'b1; l[LAMP_PED_RED] = 1'b1; end
            ST_CAR_RED_YELLOW: begin
                l[LAMP_ROAD_RED] = 1'b1; l[LAMP_ROAD_YELLOW] = 1'b1; l[LAMP_PED_RED] = 1'b1;
            end
            ST_NIGHT_FLASH:    l[LAMP_ROAD_YELLOW] = blink;
            default:           l = 5'b00000;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-CLK_PER_SEC counter producing a one-cycle seconds tick;
// restart forces the count back to zero so each phase starts a full second.
module tick_prescaler #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          tick_r;

    // Next count: restart to zero, wrap at CNT_MAX, else increment
    always_comb begin
        cnt_nx_s = cnt_r;
        if (restart) begin
            cnt_nx_s = {CW{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_nx_s = {CW{1'b0}};
        end else begin
            cnt_nx_s = cnt_r + CW'(1);
        end
    end

    // Count register; tick is registered so it is high exactly while cnt_r == CNT_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= (CNT_MAX == {CW{1'b0}});
        end else begin
            cnt_r  <= cnt_nx_s;
            tick_r <= (cnt_nx_s == CNT_MAX);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Request-driven pedestrian crossing controller with night flashing mode.
// Optional ped_countdown output is built when PED_COUNTDOWN_EN is defined.
module ped_crossing_ctrl
    import ped_crossing_pkg::*;
#(
    parameter int CLK_PER_SEC     = 50_000_000,
    parameter int T_CAR_GREEN_MIN = 10,
    parameter int T_YELLOW        = 3,
    parameter int T_ALL_RED       = 2,
    parameter int T_PED_GREEN     = 8,
    parameter int T_PED_FLASH     = 4,
    parameter int T_RED_YELLOW    = 2,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_req,
    input  logic night_mode,
    output logic road_red,
    output logic road_yellow,
    output logic road_green,
    output logic ped_red,
    output logic ped_green,
    output logic wait_lamp
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0] ped_countdown
`endif
);

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  timer_r, timer_nx_s;
    logic              blink_r, blink_nx_s;
    logic              pend_r, pend_nx_s;
    logic [1:0]        req_sync_r, night_sync_r;
    logic              req_prev_r;
    logic [LAMP_W-1:0] lamp_r;
    logic              tick_s, entry_s, last_s, rise_s, night_s;

    function automatic logic [CNT_W-1:0] load_time(input state_t st);
        case (st)
            ST_CAR_GREEN:      return CNT_W'(T_CAR_GREEN_MIN);
            ST_CAR_YELLOW:     return CNT_W'(T_YELLOW);
            ST_ALL_RED_1:      return CNT_W'(T_ALL_RED);
            ST_PED_GREEN:      return CNT_W'(T_PED_GREEN);
            ST_PED_FLASH:      return CNT_W'(T_PED_FLASH);
            ST_ALL_RED_2:      return CNT_W'(T_ALL_RED);
            ST_CAR_RED_YELLOW: return CNT_W'(T_RED_YELLOW);
            default:           return {CNT_W{1'b0}};
        endcase
    endfunction

    tick_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (entry_s),
        .tick    (tick_s)
    );

    assign night_s = night_sync_r[1];
    assign rise_s  = req_sync_r[1] & ~req_prev_r;
    assign last_s  = tick_s && (timer_r == CNT_W'(1));

    // Next-state selection; night requests are honoured only from road green
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_CAR_GREEN: begin
                if (night_s) begin
                    state_nx_s = ST_NIGHT_FLASH;
                end else if ((timer_r == {CNT_W{1'b0}}) && pend_r) begin
                    state_nx_s = ST_CAR_YELLOW;
                end else begin
                    state_nx_s = ST_CAR_GREEN;
                end
            end
            ST_CAR_YELLOW:     state_nx_s = last_s ? ST_ALL_RED_1      : ST_CAR_YELLOW;
            ST_ALL_RED_1:      state_nx_s = last_s ? ST_PED_GREEN      : ST_ALL_RED_1;
            ST_PED_GREEN:      state_nx_s = last_s ? ST_PED_FLASH      : ST_PED_GREEN;
            ST_PED_FLASH:      state_nx_s = last_s ? ST_ALL_RED_2      : ST_PED_FLASH;
            ST_ALL_RED_2:      state_nx_s = last_s ? ST_CAR_RED_YELLOW : ST_ALL_RED_2;
            ST_CAR_RED_YELLOW: state_nx_s = last_s ? ST_CAR_GREEN      : ST_CAR_RED_YELLOW;
            ST_NIGHT_FLASH:    state_nx_s = night_s ? ST_NIGHT_FLASH   : ST_ALL_RED_2;
            default:           state_nx_s = ST_CAR_GREEN;
        endcase
    end

    // Timer, blink and request latch; entering PED_GREEN clears a simultaneous new request
    always_comb begin
        entry_s    = (state_nx_s != state_r);
        timer_nx_s = timer_r;
        blink_nx_s = blink_r;
        pend_nx_s  = pend_r;
        if (entry_s) begin
            timer_nx_s = load_time(state_nx_s);
            blink_nx_s = 1'b1;
        end else if (tick_s) begin
            timer_nx_s = (timer_r == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : timer_r - CNT_W'(1);
            blink_nx_s = ~blink_r;
        end else begin
            timer_nx_s = timer_r;
        end
        if (entry_s && (state_nx_s == ST_PED_GREEN)) begin
            pend_nx_s = 1'b0;
        end else if (rise_s && (state_r != ST_PED_GREEN) && (state_r != ST_PED_FLASH)
                     && (state_r != ST_NIGHT_FLASH)) begin
            pend_nx_s = 1'b1;
        end else begin
            pend_nx_s = pend_r;
        end
    end

    // Synchronisers, FSM state and lamp register (decoded from next state so lamps track state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_r   <= 2'b00;
            night_sync_r <= 2'b00;
            req_prev_r   <= 1'b0;
            state_r      <= ST_CAR_GREEN;
            timer_r      <= CNT_W'(T_CAR_GREEN_MIN);
            blink_r      <= 1'b1;
            pend_r       <= 1'b0;
            lamp_r       <= lamp_decode(ST_CAR_GREEN, 1'b1);
        end else begin
            req_sync_r   <= {req_sync_r[0], ped_req};
            night_sync_r <= {night_sync_r[0], night_mode};
            req_prev_r   <= req_sync_r[1];
            state_r      <= state_nx_s;
            timer_r      <= timer_nx_s;
            blink_r      <= blink_nx_s;
            pend_r       <= pend_nx_s;
            lamp_r       <= lamp_decode(state_nx_s, blink_nx_s);
        end
    end

    assign road_red    = lamp_r[LAMP_ROAD_RED];
    assign road_yellow = lamp_r[LAMP_ROAD_YELLOW];
    assign road_green  = lamp_r[LAMP_ROAD_GREEN];
    assign ped_red     = lamp_r[LAMP_PED_RED];
    assign ped_green   = lamp_r[LAMP_PED_GREEN];
    assign wait_lamp   = pend_r;

`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] countdown_r;

    // Remaining walk time: steady phase adds the whole flashing phase still to come
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countdown_r <= {CNT_W{1'b0}};
        end else if (state_nx_s == ST_PED_GREEN) begin
            countdown_r <= timer_nx_s + CNT_W'(T_PED_FLASH);
        end else if (state_nx_s == ST_PED_FLASH) begin
            countdown_r <= timer_nx_s;
        end else begin
            countdown_r <= {CNT_W{1'b0}};
        end
    end

    assign ped_countdown = countdown_r;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed self-checking bench for ped_crossing_ctrl with a 4-cycle second;
// countdown checks are compiled in when PED_COUNTDOWN_EN is defined.
module tb_ped_crossing_ctrl;

    localparam logic [4:0] L_CG     = 5'b00110;
    localparam logic [4:0] L_CY     = 5'b01010;
    localparam logic [4:0] L_AR     = 5'b10010;
    localparam logic [4:0] L_PG     = 5'b10001;
    localparam logic [4:0] L_PF_OFF = 5'b10000;
    localparam logic [4:0] L_CRY    = 5'b11010;
    localparam logic [4:0] L_NF_ON  = 5'b01000;
    localparam logic [4:0] L_NF_OFF = 5'b00000;

    logic clk = 1'b0;
    logic rst_n, ped_req, night_mode;
    logic road_red, road_yellow, road_green, ped_red, ped_green, wait_lamp;
`ifdef PED_COUNTDOWN_EN
    logic [7:0] ped_countdown;
`endif

    int n_vec = 0;
    int n_err = 0;
    int edge_n = -1;

    always #5 clk = ~clk;

    ped_crossing_ctrl #(
        .CLK_PER_SEC(4), .T_CAR_GREEN_MIN(3), .T_YELLOW(1), .T_ALL_RED(1),
        .T_PED_GREEN(2), .T_PED_FLASH(2), .T_RED_YELLOW(1), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night_mode(night_mode),
        .road_red(road_red), .road_yellow(road_yellow), .road_green(road_green),
        .ped_red(ped_red), .ped_green(ped_green), .wait_lamp(wait_lamp)
`ifdef PED_COUNTDOWN_EN
        , .ped_countdown(ped_countdown)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [4:0] lamps_now();
        return {road_red, road_yellow, road_green, ped_red, ped_green};
    endfunction

    // Advance to absolute edge number tgt (edge 0 = first rising edge after reset release)
    task automatic step_to(input int tgt);
        while (edge_n < tgt) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ped_req = 1'b0;
        night_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edge_n = -1;
    endtask

    task automatic run_idle(input string tag, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            step_to(edge_n + 1);
            if ((lamps_now() !== L_CG) || (wait_lamp !== 1'b0)) bad++;
        end
        check_value(tag, bad, 0);
    endtask

    task automatic check_cd(input string tag, input int exp);
`ifdef PED_COUNTDOWN_EN
        check_value(tag, ped_countdown, exp);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        ped_req = 1'b0;
        night_mode = 1'b0;
        #12;
        check_value("rst_lamps", lamps_now(), L_CG);
        check_value("rst_wait", wait_lamp, 1'b0);
        check_cd("rst_cd", 0);

        // Idle: no request, road stays green
        do_reset();
        run_idle("idle_100", 100);

        // One-cycle press at edge 2
        do_reset();
        step_to(1);  ped_req = 1'b1;
        step_to(2);  ped_req = 1'b0;
        step_to(3);  check_value("wait_early", wait_lamp, 1'b0);
        step_to(4);  check_value("wait_rise", wait_lamp, 1'b1);
        step_to(11); check_value("cg_e11", lamps_now(), L_CG);
        step_to(12); check_value("cy_e12", lamps_now(), L_CY);
        step_to(19); check_value("ar1_e19", lamps_now(), L_AR);
        step_to(20); check_value("pg_e20", lamps_now(), L_PG);
                     check_value("pg_wait0", wait_lamp, 1'b0);
                     check_cd("cd_e20", 4);
        step_to(24); check_cd("cd_e24", 3);
        step_to(28); check_value("pf_on_e28", lamps_now(), L_PG);
                     check_cd("cd_e28", 2);
        step_to(31); check_value("pf_on_e31", lamps_now(), L_PG);
        step_to(32); check_value("pf_off_e32", lamps_now(), L_PF_OFF);
                     check_cd("cd_e32", 1);
        step_to(35); check_value("pf_off_e35", lamps_now(), L_PF_OFF);
        step_to(36); check_value("ar2_e36", lamps_now(), L_AR);
                     check_cd("cd_e36", 0);
        step_to(40); check_value("cry_e40", lamps_now(), L_CRY);
        step_to(43); check_value("cry_e43", lamps_now(), L_CRY);
        step_to(44); check_value("cg_e44", lamps_now(), L_CG);

        // Second crossing; press held through PED_GREEN ignored, new press in ALL_RED_2 held
        step_to(45); ped_req = 1'b1;
        step_to(46); ped_req = 1'b0;
        step_to(48); check_value("wait_e48", wait_lamp, 1'b1);
        step_to(56); check_value("cg_e56", lamps_now(), L_CG);
        step_to(57); check_value("cy_e57", lamps_now(), L_CY);
        step_to(65); check_value("pg_e65", lamps_now(), L_PG);
                     check_value("pg_wait_e65", wait_lamp, 1'b0);
        step_to(66); ped_req = 1'b1;
        step_to(72); check_value("held_pg", wait_lamp, 1'b0);
        step_to(76); ped_req = 1'b0;
        step_to(79); check_value("held_pf", wait_lamp, 1'b0);
        step_to(81); check_value("ar2_e81", lamps_now(), L_AR);
                     ped_req = 1'b1;
        step_to(84); check_value("ar2_press", wait_lamp, 1'b1);
                     ped_req = 1'b0;
        step_to(88); check_value("cry_e88", lamps_now(), L_CRY);
        step_to(89); check_value("cg_e89", lamps_now(), L_CG);
        step_to(101); check_value("cg_min_hold", lamps_now(), L_CG);
                      check_value("wait_e101", wait_lamp, 1'b1);
        step_to(102); check_value("cy_after_min", lamps_now(), L_CY);

        // Night mode with a pending request
        do_reset();
        step_to(0);  ped_req = 1'b1;
        step_to(1);  ped_req = 1'b0;
        step_to(3);  check_value("n_wait", wait_lamp, 1'b1);
        step_to(4);  night_mode = 1'b1;
        step_to(6);  check_value("n_cg_e6", lamps_now(), L_CG);
        step_to(7);  check_value("nf_on_e7", lamps_now(), L_NF_ON);
        step_to(10); check_value("nf_on_e10", lamps_now(), L_NF_ON);
        step_to(11); check_value("nf_off_e11", lamps_now(), L_NF_OFF);
        step_to(14); check_value("nf_off_e14", lamps_now(), L_NF_OFF);
        step_to(15); check_value("nf_on_e15", lamps_now(), L_NF_ON);
        step_to(16); night_mode = 1'b0;
        step_to(18); check_value("nf_on_e18", lamps_now(), L_NF_ON);
        step_to(19); check_value("n_ar2_e19", lamps_now(), L_AR);
        step_to(22); check_value("n_ar2_e22", lamps_now(), L_AR);
        step_to(23); check_value("n_cry_e23", lamps_now(), L_CRY);
        step_to(27); check_value("n_cg_e27", lamps_now(), L_CG);
                     check_value("n_wait_e27", wait_lamp, 1'b1);
        step_to(39); check_value("n_cg_e39", lamps_now(), L_CG);
        step_to(40); check_value("n_cy_e40", lamps_now(), L_CY);
        step_to(48); check_value("n_pg_e48", lamps_now(), L_PG);
        step_to(58); check_value("n_pf_e58", lamps_now(), L_PG);
                     check_cd("n_cd_e58", 2);

        // Asynchronous reset mid PED_FLASH
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_rst_lamps", lamps_now(), L_CG);
        check_value("mid_rst_wait", wait_lamp, 1'b0);
        check_cd("mid_rst_cd", 0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_n = -1;
        run_idle("post_rst_idle", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
